// File: rtl/pulse_count_pkg.sv
// Shared types and defaults for the pulse-count record stream.
// The record is laid out {seq, ts, count}, MSB first.
package pulse_count_pkg;

  localparam int PCS_COUNTER_WIDTH = 24;
  localparam int PCS_TS_WIDTH      = 32;
  localparam int PCS_SEQ_WIDTH     = 8;
  localparam int DROP_CNT_WIDTH    = 16;

  typedef struct packed {
    logic [PCS_SEQ_WIDTH-1:0]     seq;
    logic [PCS_TS_WIDTH-1:0]      ts;
    logic [PCS_COUNTER_WIDTH-1:0] count;
  } pcs_rec_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head visible whenever not empty, zero when empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_en, rd_en;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign wr_en = push && (!full || pop) && !clear;
  assign rd_en = pop && !empty && !clear;
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(wr_en) - LW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is unreset; the empty gate on pop_dat hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/pulse_count_stream.sv
// Tags window counts with seq/timestamp, buffers them in a FWFT FIFO and streams them out.
// Define PCS_MOVAVG_EN to add a moving average of the last 2**AVG_LOG2 counts on m_avg.
module pulse_count_stream
  import pulse_count_pkg::*;
#(
  parameter int COUNTER_WIDTH = PCS_COUNTER_WIDTH,
  parameter int FIFO_DEPTH    = 16,
  parameter int TS_WIDTH      = PCS_TS_WIDTH,
  parameter int SEQ_WIDTH     = PCS_SEQ_WIDTH,
  parameter int AVG_LOG2      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [COUNTER_WIDTH-1:0]      count_in,
  input  logic                          count_valid_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [COUNTER_WIDTH-1:0]      m_count,
  output logic [TS_WIDTH-1:0]           m_timestamp,
  output logic [SEQ_WIDTH-1:0]          m_seq,
  output logic [COUNTER_WIDTH-1:0]      m_avg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_CNT_WIDTH-1:0]     drop_cnt,
  output logic                          drop_sticky
);

  typedef struct packed {
    logic [SEQ_WIDTH-1:0]     seq;
    logic [TS_WIDTH-1:0]      ts;
    logic [COUNTER_WIDTH-1:0] count;
  } rec_t;

  logic [TS_WIDTH-1:0]       ts_q, ts_d;
  logic [SEQ_WIDTH-1:0]      seq_q, seq_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      drop_sticky_q, drop_sticky_d;
  logic                      push, pop, full, empty, drop;
  rec_t                      push_rec, head_rec;

  assign push     = count_valid_in && !clear;
  assign pop      = m_valid && m_ready;
  assign drop     = push && full && !pop;
  assign push_rec = '{seq: seq_q, ts: ts_q, count: count_in};

  sync_fifo_fwft #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .push_dat (push_rec),
    .pop      (pop),
    .pop_dat  (head_rec),
    .level    (fifo_level),
    .full     (full),
    .empty    (empty)
  );

  assign m_valid     = !empty;
  assign m_count     = head_rec.count;
  assign m_timestamp = head_rec.ts;
  assign m_seq       = head_rec.seq;
  assign drop_cnt    = drop_cnt_q;
  assign drop_sticky = drop_sticky_q;

  always_comb begin
    ts_d          = ts_q + TS_WIDTH'(1);
    seq_d         = seq_q;
    drop_cnt_d    = drop_cnt_q;
    drop_sticky_d = drop_sticky_q;
    if (clear) begin
      ts_d          = '0;
      seq_d         = '0;
      drop_cnt_d    = '0;
      drop_sticky_d = 1'b0;
    end else begin
      // Sequence advances on every strobe so downstream sees drops as gaps.
      if (count_valid_in) seq_d = seq_q + SEQ_WIDTH'(1);
      if (drop) begin
        drop_sticky_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q          <= '0;
      seq_q         <= '0;
      drop_cnt_q    <= '0;
      drop_sticky_q <= 1'b0;
    end else begin
      ts_q          <= ts_d;
      seq_q         <= seq_d;
      drop_cnt_q    <= drop_cnt_d;
      drop_sticky_q <= drop_sticky_d;
    end
  end

`ifdef PCS_MOVAVG_EN
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int SW    = COUNTER_WIDTH + AVG_LOG2;

  logic [COUNTER_WIDTH-1:0] hist_q [AVG_N];
  logic [SW-1:0]            sum_q, sum_d;
  logic [COUNTER_WIDTH-1:0] avg_q, avg_d;

  always_comb begin
    sum_d = sum_q + SW'(count_in) - SW'(hist_q[AVG_N-1]);
    avg_d = COUNTER_WIDTH'(sum_d >> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AVG_N; i++) hist_q[i] <= '0;
      sum_q <= '0;
      avg_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < AVG_N; i++) hist_q[i] <= '0;
      sum_q <= '0;
      avg_q <= '0;
    end else if (count_valid_in) begin
      hist_q[0] <= count_in;
      for (int i = 1; i < AVG_N; i++) hist_q[i] <= hist_q[i-1];
      sum_q <= sum_d;
      avg_q <= avg_d;
    end
  end

  assign m_avg = avg_q;
`else
  assign m_avg = '0;
`endif

endmodule
